load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_if.sv | 22 ++
 rtl/lsu_align.sv | 48 ++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, Funct3
// access-size codes, the default bus timeout and the access legality rule.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    // Exactly one of load/store, a known size code, no unsigned stores, natural alignment.
    function automatic logic lsu_access_legal(
        input logic       rd,
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic size_ok;
        logic align_ok;
        size_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                  (f3 == F3_BU) || (f3 == F3_HU);
        case (f3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~off[0];
            2'b10:   align_ok = (off == 2'b00);
            default: align_ok = 1'b0;
        endcase
        return (rd ^ wr) && size_ok && align_ok && !(wr && f3[2]);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Memory-side bus of the load/store unit: one request/grant channel plus a
// read-data return channel.
interface lsu_if;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [31:0] BusWData;
    logic [3:0]  BusBe;
    logic        BusGnt;
    logic        BusRValid;
    logic [31:0] BusRData;

    modport master (
        output BusReq, BusWe, BusAddr, BusWData, BusBe,
        input  BusGnt, BusRValid, BusRData
    );

    modport slave (
        input  BusReq, BusWe, BusAddr, BusWData, BusBe,
        output BusGnt, BusRValid, BusRData
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store byte enables and lane replication,
// plus load lane selection with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = rword_i[8*gi +: 8];

            assign be_o[gi] = (funct3_i[1:0] == 2'b00) ? (off_i == 2'(gi)) :
                              (funct3_i[1:0] == 2'b01) ? (off_i[1] == 1'(gi / 2)) :
                                                         1'b1;

            // Byte stores copy lane 0 everywhere, halfword stores copy the low halfword.
            assign wdata_o[8*gi +: 8] = (funct3_i[1:0] == 2'b00) ? wdata_i[7:0] :
                                        (funct3_i[1:0] == 2'b01) ? wdata_i[8*(gi%2) +: 8] :
                                                                   wdata_i[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = lane_byte[off_i];
    assign sel_half = off_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        rdata_o = rword_i;
        case (funct3_i)
            F3_B:    rdata_o = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   rdata_o = {24'h0, sel_byte};
            F3_H:    rdata_o = {{16{sel_half[15]}}, sel_half};
            F3_HU:   rdata_o = {16'h0, sel_half};
            default: rdata_o = rword_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one datapath load/store into a single bus access,
// stalling the pipeline until it completes, faults or times out.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AccessErr,
    lsu_if.master       bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [29:0]      word_q, word_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        access_req;
    logic        access_legal;
    logic        timed_out;
    logic        req_c;
    logic        err_c;
    logic [2:0]  align_f3;
    logic [1:0]  align_off;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_rdata;

    assign access_req   = MemRead | MemWrite;
    assign access_legal = lsu_access_legal(MemRead, MemWrite, Funct3, Addr[1:0]);
    assign timed_out    = (cnt_q == CNT_W'(TIMEOUT));

    // The single aligner serves the incoming store in IDLE and the latched load afterwards.
    assign align_f3  = (state_q == IDLE) ? Funct3    : f3_q;
    assign align_off = (state_q == IDLE) ? Addr[1:0] : off_q;

    lsu_align u_align (
        .funct3_i (align_f3),
        .off_i    (align_off),
        .wdata_i  (WriteData),
        .rword_i  (bus.BusRData),
        .be_o     (align_be),
        .wdata_o  (align_wdata),
        .rdata_o  (align_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        req_c   = 1'b0;
        err_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_req) begin
                    if (access_legal) begin
                        word_d  = Addr[31:2];
                        be_d    = align_be;
                        wdata_d = align_wdata;
                        we_d    = MemWrite;
                        f3_d    = Funct3;
                        off_d   = Addr[1:0];
                        rdata_d = '0;
                        cnt_d   = '0;
                        state_d = REQ;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            REQ: begin
                if (timed_out) begin
                    err_c   = 1'b1;
                    state_d = DONE;
                end else begin
                    req_c = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.BusGnt) begin
                        state_d = we_q ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                if (timed_out) begin
                    err_c   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.BusRValid) begin
                        rdata_d = align_rdata;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // While reset is high the unit looks like an idle unit with cleared latches.
    assign Stall         = (reset || state_q == IDLE) ? (access_req & access_legal)
                                                      : (state_q == REQ || state_q == WAIT);
    assign AccessErr     = err_c & ~reset;
    assign ReadData      = (state_q == DONE && !reset) ? rdata_q : 32'h0;
    assign bus.BusReq    = req_c & ~reset;
    assign bus.BusWe     = we_q & ~reset;
    assign bus.BusAddr   = reset ? 32'h0 : {word_q, 2'b00};
    assign bus.BusWData  = reset ? 32'h0 : wdata_q;
    assign bus.BusBe     = reset ? 4'h0  : be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized and directed accesses, a
// scripted bus responder and an outcome monitor fed from expectation queues.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr, WriteData, ReadData;
    logic        Stall, AccessErr;

    lsu_if bus();

    load_store_unit #(.TIMEOUT(255)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .AccessErr (AccessErr),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // kind: 0 = rejected immediately, 1 = completed, 2 = completed after timeout
    typedef struct { int kind; logic [31:0] rdata; } outcome_t;
    typedef struct {
        logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;
        int gnt_dly; int rv_dly; int mode; logic [31:0] rword;
    } plan_t;

    outcome_t sb_q[$];
    plan_t    plan_q[$];
    int       req_start_cyc = 0;

    // ---------------- reference model ----------------
    function automatic bit ref_legal(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
        int size;
        if (rd == wr) return 0;
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 0;
        if (wr && f3[2]) return 0;
        size = 1 << f3[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a, logic [31:0] word);
        logic [31:0] v;
        int sh;
        case (f3[1:0])
            2'b00: begin
                sh = a[1:0] * 8;
                v = (word >> sh) & 32'hFF;
                if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                sh = a[1] * 16;
                v = (word >> sh) & 32'hFFFF;
                if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] ref_be(logic [2:0] f3, logic [31:0] a);
        logic [3:0] b;
        case (f3[1:0])
            2'b00:   b = 4'b0001 << a[1:0];
            2'b01:   b = a[1] ? 4'b1100 : 4'b0011;
            default: b = 4'b1111;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] ref_wdata(logic [2:0] f3, logic [31:0] wd);
        logic [31:0] v;
        case (f3[1:0])
            2'b00:   v = (wd & 32'hFF) * 32'h0101_0101;
            2'b01:   v = (wd & 32'hFFFF) * 32'h0001_0001;
            default: v = wd;
        endcase
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int gnt, input int rv, input int mode,
                             input logic [31:0] rword);
        outcome_t o;
        plan_t    p;
        int       exp_lat, lat;
        if (ref_legal(rd, wr, f3, a)) begin
            p.addr = a & ~32'h3; p.be = ref_be(f3, a); p.we = wr;
            p.wdata = ref_wdata(f3, wd); p.gnt_dly = gnt; p.rv_dly = rv;
            p.mode = mode; p.rword = rword;
            plan_q.push_back(p);
            o.kind  = (mode != 0) ? 2 : 1;
            o.rdata = (mode == 0 && rd) ? ref_load(f3, a, rword) : 32'h0;
            exp_lat = (mode != 0) ? 258 : (wr ? gnt + 3 : gnt + rv + 4);
        end else begin
            o.kind = 0; o.rdata = 32'h0; exp_lat = 1;
        end
        sb_q.push_back(o);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WriteData = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (Stall && lat < 400);
        $display("access rd=%0b wr=%0b f3=%03b addr=0x%08h latency=%0d", rd, wr, f3, a, lat);
        check("latency", lat, exp_lat);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            MemRead = 1'b0; MemWrite = 1'b0;
        end
    endtask

    // ---------------- bus responder ----------------
    task automatic serve();
        plan_t p;
        bit    stable, granted;
        if (plan_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_busreq: got BusReq=1 addr=0x%08h, expected no request", bus.BusAddr);
            return;
        end
        p = plan_q.pop_front();
        req_start_cyc = cyc;
        check("bus_addr", bus.BusAddr, p.addr);
        check("bus_be", {28'h0, bus.BusBe}, {28'h0, p.be});
        check("bus_we", {31'h0, bus.BusWe}, {31'h0, p.we});
        if (p.we) check("bus_wdata", bus.BusWData, p.wdata);
        stable = 1; granted = 0;
        for (int k = 0; k < 300; k++) begin
            if (!bus.BusReq) break;
            if (bus.BusAddr !== p.addr || bus.BusBe !== p.be || bus.BusWe !== p.we) stable = 0;
            if (p.mode != 1 && k == p.gnt_dly) begin
                bus.BusGnt = 1'b1;
                granted = 1;
                break;
            end
            @(posedge clk); #2;
            bus.BusGnt = 1'b0;
            bus.BusRValid = ($urandom_range(0, 3) == 0);
            bus.BusRData = $urandom;
        end
        check("bus_stable", {31'h0, stable}, 32'h1);
        if (granted && !p.we) begin
            for (int k = 0; k < 300; k++) begin
                @(posedge clk); #2;
                bus.BusGnt = 1'b0; bus.BusRValid = 1'b0; bus.BusRData = $urandom;
                if (!Stall) break;
                if (p.mode != 2 && k == p.rv_dly) begin
                    bus.BusRValid = 1'b1;
                    bus.BusRData = p.rword;
                    break;
                end
            end
        end
    endtask

    initial begin
        bus.BusGnt = 1'b0; bus.BusRValid = 1'b0; bus.BusRData = 32'h0;
        forever begin
            @(posedge clk); #2;
            bus.BusGnt = 1'b0;
            bus.BusRValid = ($urandom_range(0, 3) == 0);
            bus.BusRData = $urandom;
            if (!reset && bus.BusReq) serve();
        end
    end

    // ---------------- outcome monitor ----------------
    task automatic pop_and_compare(input int kind, input string name);
        outcome_t o;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s_unexpected: got outcome kind %0d, expected none pending", name, kind);
            return;
        end
        o = sb_q.pop_front();
        check({name, "_kind"}, kind, o.kind);
        check({name, "_rdata"}, ReadData, o.rdata);
    endtask

    initial begin
        bit prev_stall = 0;
        bit abort_seen = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0;
                abort_seen = 0;
            end else begin
                if (AccessErr && Stall) begin
                    abort_seen = 1;
                    check("timeout_cycles", cyc - req_start_cyc, 255);
                end else if (AccessErr) begin
                    pop_and_compare(0, "reject");
                end else if (prev_stall && !Stall) begin
                    pop_and_compare(abort_seen ? 2 : 1, "complete");
                    abort_seen = 0;
                end
                prev_stall = Stall;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        Funct3 = 3'b000; Addr = 32'h0; WriteData = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busreq", {31'h0, bus.BusReq}, 32'h0);
        check("rst_buswe", {31'h0, bus.BusWe}, 32'h0);
        check("rst_busaddr", bus.BusAddr, 32'h0);
        check("rst_buswdata", bus.BusWData, 32'h0);
        check("rst_busbe", {28'h0, bus.BusBe}, 32'h0);
        check("rst_readdata", ReadData, 32'h0);
        check("rst_accesserr", {31'h0, AccessErr}, 32'h0);
        check("rst_stall_idle", {31'h0, Stall}, 32'h0);
        MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h0000_0010;
        #1;
        check("rst_stall_legal", {31'h0, Stall}, 32'h1);
        check("rst_busreq_legal", {31'h0, bus.BusReq}, 32'h0);
        @(posedge clk); #1;
        MemRead = 1'b0; reset = 1'b0;

        // Directed cases
        do_access(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 0, 32'h0);
        do_access(1, 0, 3'b001, 32'h0000_2002, 32'h0, 0, 0, 0, 32'h8001_1234);
        do_access(1, 0, 3'b101, 32'h0000_2002, 32'h0, 0, 0, 0, 32'h8001_1234);
        do_access(1, 0, 3'b010, 32'h0000_3001, 32'h0, 0, 0, 0, 32'h0);
        do_access(1, 0, 3'b010, 32'h0000_4000, 32'h0, 5, 2, 0, 32'hCAFE_F00D);
        do_access(1, 0, 3'b000, 32'h0000_5001, 32'h0, 0, 1, 0, 32'h1234_F678);
        do_access(1, 0, 3'b100, 32'h0000_5003, 32'h0, 1, 0, 0, 32'h9A34_5678);
        do_access(0, 1, 3'b001, 32'h0000_6002, 32'hDEAD_BEEF, 2, 0, 0, 32'h0);
        do_access(1, 1, 3'b010, 32'h0000_7000, 32'h0, 0, 0, 0, 32'h0);
        do_access(1, 0, 3'b011, 32'h0000_7000, 32'h0, 0, 0, 0, 32'h0);
        do_access(0, 1, 3'b100, 32'h0000_7000, 32'h0, 0, 0, 0, 32'h0);
        do_access(0, 1, 3'b001, 32'h0000_7001, 32'h0, 0, 0, 0, 32'h0);
        do_access(1, 0, 3'b010, 32'h0000_8000, 32'h0, 3, 0, 2, 32'h0);
        do_access(0, 1, 3'b010, 32'h0000_8004, 32'h1111_2222, 0, 0, 1, 32'h0);

        // Reset while the load waits for read data
        begin
            plan_t p;
            p.addr = 32'h0000_9000; p.be = 4'hF; p.we = 1'b0; p.wdata = 32'h0;
            p.gnt_dly = 0; p.rv_dly = 50; p.mode = 0; p.rword = 32'h0;
            plan_q.push_back(p);
            @(posedge clk); #1;
            MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h0000_9000;
            repeat (3) @(posedge clk);
            #1;
            reset = 1'b1; MemRead = 1'b0;
            @(negedge clk);
            $display("reset in WAIT: BusReq=%0b AccessErr=%0b", bus.BusReq, AccessErr);
            check("wait_rst_busreq", {31'h0, bus.BusReq}, 32'h0);
            check("wait_rst_accesserr", {31'h0, AccessErr}, 32'h0);
            check("wait_rst_readdata", ReadData, 32'h0);
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check("post_rst_busreq", {31'h0, bus.BusReq}, 32'h0);
            check("post_rst_accesserr", {31'h0, AccessErr}, 32'h0);
            check("post_rst_stall", {31'h0, Stall}, 32'h0);
        end
        do_access(0, 1, 3'b010, 32'h0000_A000, 32'h5A5A_A5A5, 0, 0, 0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            int          op;
            bit          rd, wr;
            logic [2:0]  f3;
            logic [31:0] a;
            op = $urandom_range(0, 9);
            rd = (op <= 5); wr = (op == 0) || (op >= 6);
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (rd && !wr && $urandom_range(0, 1) == 1 && f3[1:0] != 2'b10) f3[2] = 1'b1;
            a = $urandom;
            do_access(rd, wr, f3, a, $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 3), 0, $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        idle_cycles(4);
        @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        check("plan_drained", plan_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion before 2 ms");
        $fatal(1, "watchdog");
    end

endmodule
